unified_mem_arbiter: RTL and testbench
======================================

// Module: unified_mem_arbiter
// PURPOSE
//  Shares one single-ported unified memory between the instruction-fetch port and the
//  load/store data port of the RV32I core. Issues one memory transaction at a time
//  over a req/ack handshake and returns data plus a one-cycle ack to the winning port.
//  Data has priority over fetch, with a streak limit to prevent fetch starvation.
//  Also enforces a memory timeout. Sits between the core's PC/fetch logic, the
//  data-memory path driven by memRead/memWrite, and the memory itself.
// PARAMETERS
//  ADDR_W       32  address width, both ports and memory
//  DATA_W       32  data width
//  MAX_D_STREAK 2   max consecutive data grants while a fetch waits (>=1)
//  MEM_TIMEOUT  16  cycles from mem_req rise to abort; 0 = timeout disabled
// PORTS
//  clk        in  1           clock, rising edge
//  rst        in  1           asynchronous reset, active-low
//  if_req     in  1           fetch request; held until if_ack
//  if_addr    in  ADDR_W      fetch address; stable while if_req
//  if_rdata   out DATA_W      fetched word; valid when if_ack
//  if_ack     out 1           1-cycle fetch completion pulse
//  d_req      in  1           data request; held until d_ack
//  d_we       in  1           1 = store, 0 = load
//  d_addr     in  ADDR_W      data address
//  d_wdata    in  DATA_W      store data
//  d_be       in  DATA_W/8    store byte enables
//  d_rdata    out DATA_W      load data; valid when d_ack and d_we=0
//  d_ack      out 1           1-cycle data completion pulse
//  bus_err    out 1           with the ack pulse: transaction timed out
//  mem_req    out 1           memory request, held until mem_ack
//  mem_we     out 1           memory write enable
//  mem_addr   out ADDR_W      memory address
//  mem_wdata  out DATA_W      memory write data
//  mem_be     out DATA_W/8    memory byte enables; all-ones for fetch and load
//  mem_ack    in  1           memory done; 1-cycle pulse
//  mem_rdata  in  DATA_W      read data; valid with mem_ack
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, streak=0, timer=0, all outputs 0.
//  - FSM states: IDLE, BUSY_IF, BUSY_D, DONE.
//  - IDLE, data wins when d_req & (!if_req | streak<MAX_D_STREAK):
//    latch d_we/d_addr/d_wdata/d_be into mem_*; ->BUSY_D.
//    On a data grant, streak+=1 if if_req, else streak=0.
//  - IDLE, otherwise if if_req: latch if_addr, mem_we=0, mem_be=all-ones;
//    ->BUSY_IF; streak=0.
//  - BUSY_*: mem_req=1 with latched fields stable. Timer counts from 1.
//    On mem_ack: register mem_rdata into the port rdata (loads/fetches only;
//    stores leave d_rdata unchanged); ->DONE; mem_req=0 on the next cycle.
//    If timer reaches MEM_TIMEOUT without mem_ack: rdata=0, err flag set, ->DONE.
//    mem_ack in the expiry cycle counts as success.
//  - DONE (1 cycle): pulse ack of the served port (+bus_err if flagged) -> IDLE.
//    The requester drops req at the edge ending DONE, so IDLE never re-grants
//    a finished request.
//  - Latency: request seen in IDLE at cycle t -> mem_req at t+1.
//    mem_ack at cycle m -> ack pulse at m+1. Min 3 cycles req->ack.
//  - Input changes while BUSY have no effect on the transaction in flight.
//  - mem_ack outside BUSY_* is ignored.
//  - if_ack and d_ack are never high together; bus_err=0 outside the ack pulse.
// TESTING
//  - Fetch only: if_addr=0x40, mem_ack 2 cycles after mem_req, mem_rdata=0x00500093
//    -> mem_we=0, mem_be=4'hF, if_ack 1 cycle, if_rdata=0x00500093, bus_err=0.
//  - Simultaneous: if_req and d_req (load 0x100) same cycle -> data served first,
//    fetch issued right after d_ack; never 2 acks in one cycle.
//  - Starvation: d_req held continuously with if_req, MAX_D_STREAK=2 -> grant order
//    D,D,IF,D,D,IF.
//  - Store: d_we=1, d_addr=0x200, d_wdata=0xDEADBEEF, d_be=4'b0011 -> mem_* match;
//    d_ack pulses; d_rdata unchanged.
//  - Timeout: MEM_TIMEOUT=16, no mem_ack -> after 16 cycles of mem_req: d_ack+bus_err
//    for 1 cycle, d_rdata=0; next request proceeds normally.
//  - Reset mid-op: rst low in BUSY_D -> all outputs 0 immediately; after release
//    state is IDLE and the pending mem_ack is ignored.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported memory between fetch and data ports; data wins, bounded by a streak limit.
// Latency: request in IDLE -> mem_req next cycle; mem_ack -> port ack next cycle (min 3 cycles req->ack).
// Backpressure: requesters hold req until their ack; the memory stalls us in BUSY until mem_ack or timeout.
module unified_mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 2,
    parameter int MEM_TIMEOUT  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_ack,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ack,
    output logic                bus_err,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata
);
    localparam int SW = (MAX_D_STREAK < 2) ? 1 : $clog2(MAX_D_STREAK + 1);
    localparam int TW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
    localparam logic [TW-1:0] TIMEOUT    = TW'(MEM_TIMEOUT);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D, DONE} state_t;

    state_t          state;
    state_t          next_state;
    logic [SW-1:0]   streak;
    logic [TW-1:0]   timer;
    logic            grant_d;
    logic            grant_if;
    logic            finish;
    logic            timed_out;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        grant_d    = 1'b0;
        grant_if   = 1'b0;
        finish     = 1'b0;
        timed_out  = 1'b0;
        unique case (state)
            IDLE: begin
                // streak only limits data while a fetch is actually waiting
                if (d_req && (!if_req || streak < STREAK_MAX)) begin
                    grant_d    = 1'b1;
                    next_state = BUSY_D;
                end else if (if_req) begin
                    grant_if   = 1'b1;
                    next_state = BUSY_IF;
                end
            end
            BUSY_IF, BUSY_D: begin
                if (mem_ack) begin
                    finish     = 1'b1;
                    next_state = DONE;
                end else if (MEM_TIMEOUT != 0 && timer == TIMEOUT) begin
                    finish     = 1'b1;
                    timed_out  = 1'b1;
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            streak    <= '0;
            timer     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            if_ack  <= 1'b0;
            d_ack   <= 1'b0;
            bus_err <= 1'b0;
            if (grant_d) begin
                mem_req   <= 1'b1;
                mem_we    <= d_we;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
                mem_be    <= d_we ? d_be : '1;
                streak    <= if_req ? streak + 1'b1 : '0;
                timer     <= TW'(1);
            end else if (grant_if) begin
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= if_addr;
                mem_be   <= '1;
                streak   <= '0;
                timer    <= TW'(1);
            end
            if (finish) begin
                mem_req <= 1'b0;
                timer   <= '0;
                bus_err <= timed_out;
                if (state == BUSY_IF) begin
                    if_ack   <= 1'b1;
                    if_rdata <= timed_out ? '0 : mem_rdata;
                end else begin
                    d_ack <= 1'b1;
                    if (timed_out)    d_rdata <= '0;
                    else if (!mem_we) d_rdata <= mem_rdata;
                end
            end else if ((state == BUSY_IF || state == BUSY_D) && MEM_TIMEOUT != 0) begin
                timer <= timer + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench: directed spec scenarios plus randomized traffic against a transaction-level model.
module tb_unified_mem_arbiter;
    localparam int MAXS = 2;
    localparam int TO   = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(MAXS), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_rdata(d_rdata), .d_ack(d_ack), .bus_err(bus_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] mem_model [logic [31:0]];
    logic [31:0] exp_if_rdata;
    logic [31:0] exp_d_rdata;
    int          dstreak;
    string       grant_log;

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    function automatic void model_wr(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] w;
        w = model_rd(a);
        for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
        mem_model[a] = w;
    endfunction

    task automatic test_reset();
        rst = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; d_be = '0; mem_ack = 1'b0; mem_rdata = '0;
        #12;
        n_cmp++; if ({if_ack, d_ack, bus_err, mem_req, mem_we} !== 5'b0) begin n_err++;
            $display("FAIL reset_ctrl: got if_ack/d_ack/bus_err/mem_req/mem_we=%b want 00000", {if_ack, d_ack, bus_err, mem_req, mem_we}); end
        n_cmp++; if ({mem_addr, mem_wdata, mem_be} !== 68'h0) begin n_err++;
            $display("FAIL reset_mem: got addr=%h wdata=%h be=%h want 0", mem_addr, mem_wdata, mem_be); end
        n_cmp++; if ({if_rdata, d_rdata} !== 64'h0) begin n_err++;
            $display("FAIL reset_rdata: got if_rdata=%h d_rdata=%h want 0", if_rdata, d_rdata); end
        @(negedge clk); rst = 1'b1;
        exp_if_rdata = '0; exp_d_rdata = '0; dstreak = 0;
    endtask

    task automatic test_fetch();
        @(negedge clk); if_req = 1'b1; if_addr = 32'h40;
        @(negedge clk);
        n_cmp++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_be !== 4'hF || mem_addr !== 32'h40) begin n_err++;
            $display("FAIL fetch_issue: got req=%b we=%b be=%h addr=%h want 1 0 f 00000040", mem_req, mem_we, mem_be, mem_addr); end
        mem_rdata = 32'hFFFF_0000;
        @(negedge clk);
        @(negedge clk); mem_ack = 1'b1; mem_rdata = 32'h0050_0093;
        @(negedge clk); mem_ack = 1'b0; mem_rdata = $urandom;
        n_cmp++; if (if_ack !== 1'b1 || d_ack !== 1'b0 || bus_err !== 1'b0 || if_rdata !== 32'h0050_0093) begin n_err++;
            $display("FAIL fetch_ack: got if_ack=%b d_ack=%b err=%b rdata=%h want 1 0 0 00500093", if_ack, d_ack, bus_err, if_rdata); end
        n_cmp++; if (mem_req !== 1'b0) begin n_err++;
            $display("FAIL fetch_req_drop: got mem_req=%b want 0", mem_req); end
        if_req = 1'b0; exp_if_rdata = 32'h0050_0093; dstreak = 0;
        @(negedge clk);
        n_cmp++; if (if_ack !== 1'b0) begin n_err++;
            $display("FAIL fetch_pulse: got if_ack=%b one cycle later, want 0", if_ack); end
    endtask

    task automatic test_store();
        @(negedge clk); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011;
        @(negedge clk);
        n_cmp++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h200 || mem_wdata !== 32'hDEAD_BEEF || mem_be !== 4'b0011) begin n_err++;
            $display("FAIL store_issue: got req=%b we=%b addr=%h wdata=%h be=%b want 1 1 00000200 deadbeef 0011",
                     mem_req, mem_we, mem_addr, mem_wdata, mem_be); end
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        @(negedge clk); mem_ack = 1'b0;
        n_cmp++; if (d_ack !== 1'b1 || if_ack !== 1'b0 || bus_err !== 1'b0 || d_rdata !== exp_d_rdata) begin n_err++;
            $display("FAIL store_ack: got d_ack=%b if_ack=%b err=%b d_rdata=%h want 1 0 0 %h", d_ack, if_ack, bus_err, d_rdata, exp_d_rdata); end
        d_req = 1'b0; d_we = 1'b0; model_wr(32'h200, 32'hDEAD_BEEF, 4'b0011); dstreak = 0;
        @(negedge clk);
        n_cmp++; if (d_ack !== 1'b0) begin n_err++;
            $display("FAIL store_pulse: got d_ack=%b one cycle later, want 0", d_ack); end
    endtask

    // Random requesters plus a memory responder; grants and payloads are predicted transaction by transaction.
    task automatic traffic(input int n_f, input int n_d, input int p_arr, input bit fix_d);
        int f_left = n_f;
        int d_left = n_d;
        int cyc = 0;
        int wait_cnt = 0;
        bit f_pend = 1'b0, d_pend = 1'b0, inflight = 1'b0, acked = 1'b0, cur_is_d = 1'b0;
        bit expect_issue = 1'b0, done_now;
        logic [31:0] cur_addr = '0, cur_rd = '0, cur_wdata = '0;
        logic [3:0]  cur_be = '0;
        logic        cur_we = 1'b0;
        grant_log = "";
        repeat (2) @(negedge clk);
        while ((f_left > 0 || d_left > 0 || f_pend || d_pend || inflight) && cyc < 3000) begin
            @(negedge clk); cyc++;
            done_now = 1'b0;
            n_cmp++; if (if_ack === 1'b1 && d_ack === 1'b1) begin n_err++;
                $display("FAIL double_ack: got if_ack=1 d_ack=1 want at most one"); end
            if (expect_issue) begin
                n_cmp++; if (mem_req !== 1'b1) begin n_err++;
                    $display("FAIL issue_latency: got mem_req=%b one cycle after request in idle, want 1", mem_req); end
            end
            if (inflight && acked) begin
                done_now = 1'b1; mem_ack = 1'b0; mem_rdata = $urandom;
                n_cmp++;
                if (cur_is_d) begin
                    if (d_ack !== 1'b1 || if_ack !== 1'b0 || bus_err !== 1'b0 || d_rdata !== exp_d_rdata) begin n_err++;
                        $display("FAIL d_done: got d_ack=%b if_ack=%b err=%b d_rdata=%h want 1 0 0 %h", d_ack, if_ack, bus_err, d_rdata, exp_d_rdata); end
                    d_pend = 1'b0; d_req = 1'b0;
                end else begin
                    if (if_ack !== 1'b1 || d_ack !== 1'b0 || bus_err !== 1'b0 || if_rdata !== exp_if_rdata) begin n_err++;
                        $display("FAIL if_done: got if_ack=%b d_ack=%b err=%b if_rdata=%h want 1 0 0 %h", if_ack, d_ack, bus_err, if_rdata, exp_if_rdata); end
                    f_pend = 1'b0; if_req = 1'b0;
                end
                n_cmp++; if (mem_req !== 1'b0) begin n_err++;
                    $display("FAIL req_drop: got mem_req=%b in ack cycle, want 0", mem_req); end
                inflight = 1'b0; acked = 1'b0;
            end else begin
                n_cmp++; if ({if_ack, d_ack, bus_err} !== 3'b000) begin n_err++;
                    $display("FAIL spurious_ack: got if_ack/d_ack/bus_err=%b want 000", {if_ack, d_ack, bus_err}); end
            end
            if (!done_now && inflight) begin
                n_cmp++; if (mem_req !== 1'b1 || mem_addr !== cur_addr) begin n_err++;
                    $display("FAIL hold: got mem_req=%b addr=%h want 1 %h", mem_req, mem_addr, cur_addr); end
            end else if (!done_now && mem_req === 1'b1) begin
                if (!f_pend && !d_pend) begin
                    n_cmp++; n_err++;
                    $display("FAIL spurious_req: got mem_req=1 with nothing pending, want 0");
                end else begin
                    cur_is_d = d_pend && (!f_pend || dstreak < MAXS);
                    if (cur_is_d) begin
                        dstreak = f_pend ? dstreak + 1 : 0;
                        grant_log = {grant_log, "D"};
                        cur_addr = d_addr; cur_we = d_we; cur_wdata = d_wdata; cur_be = d_we ? d_be : 4'hF;
                    end else begin
                        dstreak = 0;
                        grant_log = {grant_log, "I"};
                        cur_addr = if_addr; cur_we = 1'b0; cur_wdata = mem_wdata; cur_be = 4'hF;
                    end
                    n_cmp++; if (mem_addr !== cur_addr || mem_we !== cur_we || mem_be !== cur_be || (cur_we && mem_wdata !== cur_wdata)) begin n_err++;
                        $display("FAIL grant_fields: got addr=%h we=%b be=%h wdata=%h want %h %b %h %h (data=%0d)",
                                 mem_addr, mem_we, mem_be, mem_wdata, cur_addr, cur_we, cur_be, cur_wdata, cur_is_d); end
                    cur_rd = model_rd(cur_addr);
                    wait_cnt = ($urandom_range(0, 9) == 0) ? TO - 1 : int'($urandom_range(0, 3));
                    inflight = 1'b1;
                end
            end
            if (inflight && !acked) begin
                if (wait_cnt == 0) begin
                    mem_ack = 1'b1; acked = 1'b1;
                    if (cur_we) begin
                        mem_rdata = $urandom;
                        model_wr(cur_addr, cur_wdata, cur_be);
                    end else begin
                        mem_rdata = cur_rd;
                        if (cur_is_d) exp_d_rdata = cur_rd;
                        else          exp_if_rdata = cur_rd;
                    end
                end else begin
                    wait_cnt--; mem_rdata = $urandom;
                end
            end
            if (!f_pend && f_left > 0 && int'($urandom_range(0, 99)) < p_arr) begin
                f_pend = 1'b1; f_left--; if_req = 1'b1;
                if_addr = 32'h1000 + (32'($urandom_range(0, 63)) << 2);
            end
            if (!d_pend && d_left > 0 && int'($urandom_range(0, 99)) < p_arr) begin
                d_pend = 1'b1; d_left--; d_req = 1'b1;
                d_we    = fix_d ? 1'b0 : 1'($urandom_range(0, 1));
                d_addr  = fix_d ? 32'h100 : (32'($urandom_range(0, 15)) << 2);
                d_wdata = $urandom;
                d_be    = 4'($urandom_range(1, 15));
            end
            expect_issue = !inflight && !done_now && (f_pend || d_pend);
        end
        if (cyc >= 3000) begin
            n_cmp++; n_err++;
            $display("FAIL traffic_budget: got %0d cycles without draining, want fewer than 3000", cyc);
        end
        if_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic test_simultaneous();
        traffic(1, 1, 100, 1'b1);
        n_cmp++; if (grant_log != "DI") begin n_err++;
            $display("FAIL simultaneous_order: got %s want DI", grant_log); end
    endtask

    task automatic test_starvation();
        traffic(2, 4, 100, 1'b0);
        n_cmp++; if (grant_log != "DDIDDI") begin n_err++;
            $display("FAIL starvation_order: got %s want DDIDDI", grant_log); end
    endtask

    task automatic test_timeout();
        int req_cycles = 0;
        int cyc = 0;
        bit seen = 1'b0;
        @(negedge clk); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; d_be = 4'h5; d_wdata = $urandom; mem_ack = 1'b0;
        while (!seen && cyc < 60) begin
            @(negedge clk); cyc++;
            if (mem_req === 1'b1) req_cycles++;
            if (d_ack === 1'b1) seen = 1'b1;
        end
        n_cmp++; if (!seen) begin n_err++;
            $display("FAIL timeout_ack: got no d_ack within 60 cycles, want one"); end
        n_cmp++; if (req_cycles != TO) begin n_err++;
            $display("FAIL timeout_len: got %0d mem_req cycles want %0d", req_cycles, TO); end
        n_cmp++; if (bus_err !== 1'b1 || d_rdata !== 32'h0 || if_ack !== 1'b0) begin n_err++;
            $display("FAIL timeout_err: got bus_err=%b d_rdata=%h if_ack=%b want 1 00000000 0", bus_err, d_rdata, if_ack); end
        d_req = 1'b0; exp_d_rdata = '0;
        @(negedge clk);
        n_cmp++; if (bus_err !== 1'b0 || d_ack !== 1'b0) begin n_err++;
            $display("FAIL timeout_pulse: got bus_err=%b d_ack=%b one cycle later, want 0 0", bus_err, d_ack); end
        d_req = 1'b1; d_addr = 32'h304;
        @(negedge clk);
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h304) begin n_err++;
            $display("FAIL post_timeout_issue: got req=%b addr=%h want 1 00000304", mem_req, mem_addr); end
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_0001;
        @(negedge clk); mem_ack = 1'b0;
        n_cmp++; if (d_ack !== 1'b1 || bus_err !== 1'b0 || d_rdata !== 32'hCAFE_0001) begin n_err++;
            $display("FAIL post_timeout_ack: got d_ack=%b err=%b d_rdata=%h want 1 0 cafe0001", d_ack, bus_err, d_rdata); end
        d_req = 1'b0; exp_d_rdata = 32'hCAFE_0001; dstreak = 0;
        @(negedge clk);
    endtask

    task automatic test_random();
        traffic(40, 40, 30, 1'b0);
        n_cmp++; if (grant_log.len() != 80) begin n_err++;
            $display("FAIL random_count: got %0d grants want 80", grant_log.len()); end
    endtask

    task automatic test_back_to_back();
        traffic(15, 15, 100, 1'b0);
        n_cmp++; if (grant_log.len() != 30) begin n_err++;
            $display("FAIL b2b_count: got %0d grants want 30", grant_log.len()); end
    endtask

    task automatic test_reset_mid_op();
        @(negedge clk); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44;
        @(negedge clk);
        n_cmp++; if (mem_req !== 1'b1) begin n_err++;
            $display("FAIL rst_mid_issue: got mem_req=%b want 1", mem_req); end
        @(negedge clk); rst = 1'b0;
        #1;
        n_cmp++; if ({mem_req, mem_we, if_ack, d_ack, bus_err} !== 5'b0 || {mem_addr, mem_wdata, mem_be} !== 68'h0 || {if_rdata, d_rdata} !== 64'h0) begin n_err++;
            $display("FAIL rst_mid_outputs: got req=%b we=%b acks=%b%b err=%b addr=%h be=%h if_rdata=%h d_rdata=%h want all 0",
                     mem_req, mem_we, if_ack, d_ack, bus_err, mem_addr, mem_be, if_rdata, d_rdata); end
        d_req = 1'b0; exp_d_rdata = '0; exp_if_rdata = '0; dstreak = 0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
        @(negedge clk); mem_ack = 1'b0;
        n_cmp++; if (mem_req !== 1'b0 || d_ack !== 1'b0 || if_ack !== 1'b0 || d_rdata !== 32'h0) begin n_err++;
            $display("FAIL stale_ack: got req=%b d_ack=%b if_ack=%b d_rdata=%h want 0 0 0 00000000", mem_req, d_ack, if_ack, d_rdata); end
        @(negedge clk);
        n_cmp++; if ({mem_req, d_ack, if_ack, bus_err} !== 4'b0) begin n_err++;
            $display("FAIL stale_idle: got req/d_ack/if_ack/err=%b want 0000", {mem_req, d_ack, if_ack, bus_err}); end
        traffic(4, 4, 60, 1'b0);
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_simultaneous();
        test_starvation();
        test_timeout();
        test_random();
        test_back_to_back();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
